weight_sched: RTL and testbench
===============================

WEIGHT_SCHED -- requirements
Module: weight_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning number of note-player channels whose harmonic weight is managed (legal 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port edit  input  1  edit-mode switch level; buttons are honoured only while high.
REQ-005 SHALL have port up_button  input  1  one-cycle pulse, raise target weight of the selected channel.
REQ-006 SHALL have port down_button  input  1  one-cycle pulse, lower target weight of the selected channel.
REQ-007 SHALL have port next_button  input  1  one-cycle pulse, advance channel selection.
REQ-008 SHALL have port beat  input  1  one-cycle pulse, ramp step strobe.
REQ-009 SHALL have port weights  output  2*NUM_CH  applied weights, channel i at bits [2i+1:2i].
REQ-010 SHALL have port sel  output  2  currently selected channel index.
REQ-011 SHALL have port busy  output  1  high while any applied weight differs from its target.

Function
REQ-012 Weight encoding SHALL be 0 = default, 1 = weight1, 2 = weight2; code 3 is never stored.
REQ-013 Each channel SHALL hold a target register and an applied register, both 2 bits.
REQ-014 With edit high, up_button alone SHALL increment target[sel], saturating at 2; down_button alone SHALL decrement it, saturating at 0; the result SHALL be visible one clock after the pulse.
REQ-015 With up_button and down_button high in the same cycle, target SHALL be unchanged.
REQ-016 With edit high, next_button SHALL advance sel by one, wrapping from NUM_CH-1 to 0; with a simultaneous up/down, the target change SHALL apply to the old sel.
REQ-017 With edit low, all three buttons SHALL be ignored; ramping SHALL continue.
REQ-018 On a beat pulse, each applied weight SHALL move exactly one step toward its target; channels already equal SHALL hold.
REQ-019 A beat and a target change in the same cycle SHALL ramp toward the pre-change target; the new target SHALL take effect from the next beat.
REQ-020 The FSM SHALL have two states: IDLE (all applied equal targets) and RAMP (any mismatch).
- IDLE->RAMP one clock after a target change creates a mismatch.
- RAMP->IDLE on the clock edge where the final beat step closes the last mismatch.
REQ-021 busy SHALL equal (state == RAMP), registered.
REQ-022 A mid-ramp target reversal SHALL redirect ramping toward the new target without skipping a step.

Reset
REQ-023 Asserting reset_n low SHALL immediately set all targets and applied weights to 0, sel to 0, state to IDLE, and busy to 0, regardless of clk.
REQ-024 After reset_n deasserts, the first honoured input SHALL take effect at the first rising clk edge.

Configuration
REQ-025 Macro WEIGHT_SCHED_RAMP_EN SHALL select ramped behaviour.
- Defined: behaviour per REQ-018..022.
- Undefined: applied weight SHALL equal target one clock after any change, beat SHALL be ignored, and busy SHALL stay 0.

Structure
REQ-026 The weight encodings (DEFAULT/WEIGHT1/WEIGHT2), the FSM state encodings and the maximum weight constant SHALL reside in the shared music-player package.
REQ-027 The per-channel target/applied pair plus step logic SHALL be a sub-module weight_step, instantiated NUM_CH times; the top SHALL hold sel, button decode and the FSM.

Verification
REQ-028 Reset, then edit=1, up_button x3 on ch0 -> target0 = 2 (saturates); with ramp, weights[1:0] = 0->1->2 on two beats; busy = 1 between the steps, then 0.
REQ-029 edit=1, next_button x3 with NUM_CH=3 -> sel = 1,2,0; up_button on sel=2 -> only weights[5:4] ramps.
REQ-030 up_button and down_button in the same cycle -> target unchanged and busy stays 0; edit=0 with up_button -> no change.
REQ-031 beat coincident with up_button at target=applied=1 -> applied stays 1 that beat, then reaches 2 on the next beat.
REQ-032 reset_n pulsed low mid-ramp (applied = 1, target = 2) -> weights = 0, sel = 0, busy = 0 asynchronously, before the next clk edge.
REQ-033 Macro undefined: up_button -> weights update one clock later with no beat required; busy stays 0.

Source files
------------

// File: rtl/weight_sched_pkg.sv
// rtl/weight_sched_pkg.sv - shared music-player constants for the weight scheduler
// Purpose: weight encodings, scheduler FSM state encodings, maximum weight and
//          the single-step ramp helper shared by weight_sched and weight_step.
// Ports:   none (package).
package weight_sched_pkg;

  // Harmonic weight codes; code 3 is never stored.
  typedef enum logic [1:0] {
    W_DEFAULT = 2'd0,
    W_WEIGHT1 = 2'd1,
    W_WEIGHT2 = 2'd2
  } weight_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  localparam logic [1:0] MAX_WEIGHT = W_WEIGHT2;

  // One step of applied toward target; equal values hold.
  function automatic logic [1:0] step_toward(input logic [1:0] applied,
                                             input logic [1:0] target);
    logic [1:0] res;
    res = applied;
    if (applied < target)
      res = applied + 2'd1;
    else if (applied > target)
      res = applied - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/weight_step.sv
// rtl/weight_step.sv - per-channel target/applied weight pair with step logic
// Purpose: holds one channel's target and applied weight. Target moves by
//          saturating inc/dec; applied follows it one step per beat when
//          WEIGHT_SCHED_RAMP_EN is defined, otherwise tracks target directly.
// Ports:   clk, reset_n (async active-low)
//          inc, dec      - already-decoded edit requests for this channel
//          beat          - ramp step strobe (ignored without WEIGHT_SCHED_RAMP_EN)
//          applied       - registered applied weight
//          mismatch_nxt  - target and applied will differ after this edge
// Macro:   WEIGHT_SCHED_RAMP_EN
module weight_step
  import weight_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       beat,
  output logic [1:0] applied,
  output logic       mismatch_nxt
);

  logic [1:0] target;
  logic [1:0] target_nxt;
  logic [1:0] applied_nxt;

  always_comb begin
    target_nxt = target;
    if (inc && (target != MAX_WEIGHT))
      target_nxt = target + 2'd1;
    else if (dec && (target != W_DEFAULT))
      target_nxt = target - 2'd1;
  end

`ifdef WEIGHT_SCHED_RAMP_EN
  // Steps toward the registered (pre-change) target, so an edit landing on
  // the same edge as a beat only influences the following beat.
  assign applied_nxt = beat ? step_toward(applied, target) : applied;
`else
  logic unused_beat;
  assign unused_beat = beat;
  assign applied_nxt = target_nxt;
`endif

  assign mismatch_nxt = (target_nxt != applied_nxt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target  <= W_DEFAULT;
      applied <= W_DEFAULT;
    end else begin
      target  <= target_nxt;
      applied <= applied_nxt;
    end
  end

endmodule

// File: rtl/weight_sched.sv
// rtl/weight_sched.sv - harmonic weight scheduler for NUM_CH note-player channels
// Purpose: decodes edit-mode buttons into per-channel target changes, keeps
//          the channel selection, and runs the IDLE/RAMP FSM that reports busy
//          while any applied weight still differs from its target.
// Ports:   clk, reset_n (async active-low)
//          edit                              - buttons honoured only while high
//          up_button, down_button, next_button - one-cycle button pulses
//          beat                              - ramp step strobe
//          weights[2*NUM_CH-1:0]             - applied weights, ch i at [2i+1:2i]
//          sel[1:0]                          - selected channel
//          busy                              - registered, high in RAMP
// Macro:   WEIGHT_SCHED_RAMP_EN (defined: ramped; undefined: immediate, busy=0)
module weight_sched
  import weight_sched_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                edit,
  input  logic                up_button,
  input  logic                down_button,
  input  logic                next_button,
  input  logic                beat,
  output logic [2*NUM_CH-1:0] weights,
  output logic [1:0]          sel,
  output logic                busy
);

  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  // Up and down together cancel out.
  logic up_eff;
  logic dn_eff;
  logic nx_eff;
  assign up_eff = edit & up_button & ~down_button;
  assign dn_eff = edit & down_button & ~up_button;
  assign nx_eff = edit & next_button;

  logic [NUM_CH-1:0] ch_mismatch;
  state_e            state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    // Compares against the current sel, so a simultaneous next still edits
    // the channel that was selected when the button was pressed.
    assign hit = (sel == 2'(i));

    weight_step u_step (
      .clk          (clk),
      .reset_n      (reset_n),
      .inc          (up_eff & hit),
      .dec          (dn_eff & hit),
      .beat         (beat),
      .applied      (weights[2*i +: 2]),
      .mismatch_nxt (ch_mismatch[i])
    );
  end

`ifndef WEIGHT_SCHED_RAMP_EN
  logic unused_mismatch;
  assign unused_mismatch = |ch_mismatch;
`endif

  // State is decided from the channels' next values, so RAMP is entered on the
  // edge that creates a mismatch and left on the edge whose beat closes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel   <= 2'd0;
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      if (nx_eff)
        sel <= (sel == LAST_CH) ? 2'd0 : sel + 2'd1;
`ifdef WEIGHT_SCHED_RAMP_EN
      case (state)
        ST_IDLE: begin
          if (|ch_mismatch) begin
            state <= ST_RAMP;
            busy  <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (!(|ch_mismatch)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
`else
      state <= ST_IDLE;
      busy  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_weight_sched.sv
// tb/tb_weight_sched.sv - self-checking bench for weight_sched
module tb_weight_sched;

  localparam int NUM_CH = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                edit = 1'b0;
  logic                up_button = 1'b0;
  logic                down_button = 1'b0;
  logic                next_button = 1'b0;
  logic                beat = 1'b0;
  logic [2*NUM_CH-1:0] weights;
  logic [1:0]          sel;
  logic                busy;

  always #5 clk = ~clk;

  weight_sched #(.NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .edit        (edit),
    .up_button   (up_button),
    .down_button (down_button),
    .next_button (next_button),
    .beat        (beat),
    .weights     (weights),
    .sel         (sel),
    .busy        (busy)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state
  int m_tgt[NUM_CH];
  int m_app[NUM_CH];
  int m_sel;
  bit m_busy;

  function automatic logic [2*NUM_CH-1:0] m_weights();
    logic [2*NUM_CH-1:0] w;
    for (int i = 0; i < NUM_CH; i++) w[2*i +: 2] = 2'(m_app[i]);
    return w;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_tgt[i] = 0;
      m_app[i] = 0;
    end
    m_sel  = 0;
    m_busy = 0;
  endfunction

  // Drive one cycle of inputs, clock once, advance the model, sample at +1.
  task automatic step(input bit ed, input bit up, input bit dn, input bit nx, input bit bt);
    @(negedge clk);
    edit = ed; up_button = up; down_button = dn; next_button = nx; beat = bt;
    @(posedge clk);
`ifdef WEIGHT_SCHED_RAMP_EN
    if (bt)
      for (int i = 0; i < NUM_CH; i++)
        m_app[i] += (m_tgt[i] > m_app[i]) ? 1 : (m_tgt[i] < m_app[i]) ? -1 : 0;
`endif
    if (ed) begin
      if (up && !dn && m_tgt[m_sel] < 2) m_tgt[m_sel]++;
      if (dn && !up && m_tgt[m_sel] > 0) m_tgt[m_sel]--;
      if (nx) m_sel = (m_sel + 1) % NUM_CH;
    end
    m_busy = 0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifndef WEIGHT_SCHED_RAMP_EN
      m_app[i] = m_tgt[i];
`endif
      if (m_app[i] != m_tgt[i]) m_busy = 1;
    end
    #1;
    up_button = 0; down_button = 0; next_button = 0; beat = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    model_clear();
    total++; if (weights !== '0) $display("FAIL reset_weights got %h exp 0", weights); else passed++;
    total++; if (sel !== 2'd0) $display("FAIL reset_sel got %0d exp 0", sel); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0);
`ifdef WEIGHT_SCHED_RAMP_EN
    total++; if (weights !== 6'h00 || busy !== 1'b1) $display("FAIL sat_pre w=%h busy=%b exp w=00 busy=1", weights, busy); else passed++;
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd1 || busy !== 1'b1) $display("FAIL sat_beat1 w0=%0d busy=%b exp 1/1", weights[1:0], busy); else passed++;
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd2 || busy !== 1'b0) $display("FAIL sat_beat2 w0=%0d busy=%b exp 2/0", weights[1:0], busy); else passed++;
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd2) $display("FAIL sat_hold w0=%0d exp 2", weights[1:0]); else passed++;
`else
    total++; if (weights !== 6'h02 || busy !== 1'b0) $display("FAIL sat_direct w=%h busy=%b exp 02/0", weights, busy); else passed++;
`endif
  endtask

  task automatic test_select();
    logic [1:0] exp_sel[3];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 0);
      total++; if (sel !== exp_sel[k]) $display("FAIL sel_wrap%0d got %0d exp %0d", k, sel, exp_sel[k]); else passed++;
    end
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
`ifdef WEIGHT_SCHED_RAMP_EN
    total++; if (weights !== 6'h00 || busy !== 1'b1) $display("FAIL sel_ch2_pre w=%h busy=%b exp 00/1", weights, busy); else passed++;
    step(1, 0, 0, 0, 1);
`endif
    total++; if (weights !== 6'h10 || busy !== 1'b0) $display("FAIL sel_ch2 w=%h busy=%b exp 10/0", weights, busy); else passed++;
    // Up and next together: the edit lands on the old selection (ch2).
    step(1, 1, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    total++; if (weights !== 6'h20 || sel !== 2'd0) $display("FAIL sel_old w=%h sel=%0d exp 20/0", weights, sel); else passed++;
  endtask

  task automatic test_cancel_and_edit_off();
    do_reset();
    step(1, 1, 1, 0, 0);
    total++; if (weights !== 6'h00 || busy !== 1'b0) $display("FAIL both_btn w=%h busy=%b exp 00/0", weights, busy); else passed++;
    step(1, 0, 0, 0, 0);
    total++; if (busy !== 1'b0) $display("FAIL both_btn_busy got %b exp 0", busy); else passed++;
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    total++; if (weights !== 6'h00 || sel !== 2'd0 || busy !== 1'b0) $display("FAIL edit_off w=%h sel=%0d busy=%b exp 00/0/0", weights, sel, busy); else passed++;
  endtask

  task automatic test_beat_coincident();
    do_reset();
    step(1, 1, 0, 0, 0);
`ifdef WEIGHT_SCHED_RAMP_EN
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd1 || busy !== 1'b0) $display("FAIL coin_setup w0=%0d busy=%b exp 1/0", weights[1:0], busy); else passed++;
    step(1, 1, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd1 || busy !== 1'b1) $display("FAIL coin_same w0=%0d busy=%b exp 1/1", weights[1:0], busy); else passed++;
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd2 || busy !== 1'b0) $display("FAIL coin_next w0=%0d busy=%b exp 2/0", weights[1:0], busy); else passed++;
    // Reversal mid-ramp: target 2 -> 0 while applied is at 2, then back up.
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    total++; if (weights[1:0] !== 2'd1 || busy !== 1'b1) $display("FAIL rev_step w0=%0d busy=%b exp 1/1", weights[1:0], busy); else passed++;
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd1 || busy !== 1'b0) $display("FAIL rev_settle w0=%0d busy=%b exp 1/0", weights[1:0], busy); else passed++;
`else
    total++; if (weights[1:0] !== 2'd1 || busy !== 1'b0) $display("FAIL direct_up w0=%0d busy=%b exp 1/0", weights[1:0], busy); else passed++;
    step(1, 0, 0, 0, 1);
    total++; if (weights[1:0] !== 2'd1) $display("FAIL beat_ignored w0=%0d exp 1", weights[1:0]); else passed++;
`endif
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    total++; if (weights !== m_weights() || busy !== m_busy) $display("FAIL mid_pre w=%h busy=%b exp %h/%b", weights, busy, m_weights(), m_busy); else passed++;
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    total++; if (weights !== '0 || sel !== 2'd0 || busy !== 1'b0) $display("FAIL mid_reset w=%h sel=%0d busy=%b exp 00/0/0", weights, sel, busy); else passed++;
    #1 reset_n = 1'b1;
  endtask

  task automatic test_random();
    int errs;
    bit ed, up, dn, nx, bt;
    errs = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ed = ($urandom_range(0, 3) != 0);
      up = ($urandom_range(0, 2) == 0);
      dn = ($urandom_range(0, 3) == 0);
      nx = ($urandom_range(0, 4) == 0);
      bt = ($urandom_range(0, 2) == 0);
      step(ed, up, dn, nx, bt);
      total++;
      if (weights !== m_weights() || sel !== 2'(m_sel) || busy !== m_busy) begin
        if (errs < 10)
          $display("FAIL random[%0d] w=%h sel=%0d busy=%b exp %h/%0d/%b", k, weights, sel, busy, m_weights(), m_sel, m_busy);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_saturate();
    test_select();
    test_cancel_and_edit_off();
    test_beat_coincident();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
